// File: rtl/noise_generator_multichannel.sv
// Multi-channel SID-style noise source: per-channel phase accumulator whose STEP_BIT
// rising edge advances a long/short-tap Fibonacci LFSR; programmed via a register-write port.
module noise_generator_multichannel #(
    parameter int                   CHANNELS    = 4,
    parameter int                   LFSR_BITS   = 23,
    parameter int                   LONG_TAP    = 17,
    parameter int                   SHORT_TAP   = 16,
    parameter logic [LFSR_BITS-1:0] SEED        = 23'b01101110010010000101011,
    parameter int                   FREQ_BITS   = 16,
    parameter int                   ACCUM_BITS  = 24,
    parameter int                   STEP_BIT    = 19,
    parameter int                   OUTPUT_BITS = 12,
    localparam int                  CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_en,
    input  logic [CH_W-1:0]                 wr_ch,
    input  logic [1:0]                      wr_addr,
    input  logic [31:0]                     wr_data,
    output logic [CHANNELS*OUTPUT_BITS-1:0] dout,
    output logic [CHANNELS-1:0]             step
);

    function automatic logic [7:0] f_map(input logic [LFSR_BITS-1:0] v);
        return {v[LFSR_BITS-1],  v[LFSR_BITS-3],  v[LFSR_BITS-7],  v[LFSR_BITS-10],
                v[LFSR_BITS-12], v[LFSR_BITS-16], v[LFSR_BITS-19], v[LFSR_BITS-21]};
    endfunction

    // A zero seed would lock the LFSR, so it is swapped for the default seed.
    logic [LFSR_BITS-1:0] w_seed_in;
    logic                 w_unused_data;
    assign w_seed_in     = (wr_data[LFSR_BITS-1:0] == '0) ? SEED : wr_data[LFSR_BITS-1:0];
    assign w_unused_data = ^wr_data;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [ACCUM_BITS-1:0] r_acc;
        logic [FREQ_BITS-1:0]  r_freq;
        logic                  r_short;
        logic                  r_hold;
        logic [LFSR_BITS-1:0]  r_seed;
        logic [LFSR_BITS-1:0]  r_lfsr;
        logic                  r_step;

        logic                  w_sel, w_wr_freq, w_wr_ctrl, w_wr_seed;
        logic                  w_hold, w_rise, w_fb;
        logic [ACCUM_BITS-1:0] w_sum;

        assign w_sel     = wr_en && (wr_ch == CH_W'(c));
        assign w_wr_freq = w_sel && (wr_addr == 2'd0);
        assign w_wr_ctrl = w_sel && (wr_addr == 2'd1);
        assign w_wr_seed = w_sel && (wr_addr == 2'd2);

        assign w_sum  = r_acc + ACCUM_BITS'(r_freq);
        assign w_rise = ~r_acc[STEP_BIT] & w_sum[STEP_BIT];
        // Setting hold takes effect on the write edge (beats a coincident step);
        // clearing it releases the channel one edge later.
        assign w_hold = r_hold | (w_wr_ctrl & wr_data[1]);
        assign w_fb   = r_lfsr[LFSR_BITS-1] ^ (r_short ? r_lfsr[SHORT_TAP] : r_lfsr[LONG_TAP]);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_acc   <= '0;
                r_freq  <= '0;
                r_short <= 1'b0;
                r_hold  <= 1'b0;
                r_seed  <= SEED;
                r_lfsr  <= SEED;
                r_step  <= 1'b0;
            end else begin
                if (w_wr_freq) r_freq <= wr_data[FREQ_BITS-1:0];
                if (w_wr_ctrl) {r_hold, r_short} <= wr_data[1:0];
                if (w_wr_seed) r_seed <= w_seed_in;

                if (w_hold) begin
                    r_acc  <= '0;
                    r_lfsr <= w_wr_seed ? w_seed_in : r_seed;
                    r_step <= 1'b0;
                end else begin
                    r_acc <= w_sum;
                    if (w_wr_seed) begin
                        r_lfsr <= w_seed_in;
                        r_step <= 1'b0;
                    end else if (w_rise) begin
                        r_lfsr <= {r_lfsr[LFSR_BITS-2:0], w_fb};
                        r_step <= 1'b1;
                    end else begin
                        r_step <= 1'b0;
                    end
                end
            end
        end

        assign dout[c*OUTPUT_BITS +: OUTPUT_BITS] = OUTPUT_BITS'(f_map(r_lfsr)) << (OUTPUT_BITS - 8);
        assign step[c] = r_step;
    end

endmodule
